// File: rtl/dec_pkg.sv
// dec_pkg: shared types and constants for decoder_pipe.
//   state_t     - FSM state encoding (IDLE, HOLD, SCAN)
//   MODE_DIRECT - in_mode value for a single-beat decode
//   MODE_SCAN   - in_mode value for a walk from in_sel up to the top index
package dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_SCAN
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dec_onehot_core.sv
// dec_onehot_core: combinational index-to-one-hot converter.
//   i_idx  [SEL_W]    index to decode
//   i_en   [1]        word enabled; when low no bit is active
//   o_word [2**SEL_W] decoded word
// Polarity macro: DECODER_PIPE_ACTIVE_LOW_EN selects one-cold output
// (active bit 0, idle word all ones).
module dec_onehot_core #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      i_idx,
  input  logic                  i_en,
  output logic [(2**SEL_W)-1:0] o_word
);

  logic [(2**SEL_W)-1:0] w_hot;

  always_comb begin
    w_hot = '0;
    if (i_en) begin
      w_hot[i_idx] = 1'b1;
    end
  end

`ifdef DECODER_PIPE_ACTIVE_LOW_EN
  assign o_word = ~w_hot;
`else
  assign o_word = w_hot;
`endif

endmodule

// File: rtl/decoder_pipe.sv
// decoder_pipe: valid/ready pipelined index decoder with direct and scan modes.
//   clk, rst       clock, asynchronous active-high reset
//   in_valid/ready request handshake; in_sel index or scan start; in_mode 0 direct / 1 scan
//   out_valid/ready beat handshake
//   out_onehot     decoded word for out_idx (zero when idle)
//   out_idx        index currently presented
//   out_last       final beat of the current request
// Polarity macro: DECODER_PIPE_ACTIVE_LOW_EN makes out_onehot one-cold.
module decoder_pipe #(
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**SEL_W)-1:0] out_onehot,
  output logic [SEL_W-1:0]      out_idx,
  output logic                  out_last
);

  import dec_pkg::*;

  localparam logic [SEL_W-1:0] LAST_IDX = '1;

  state_t           r_state;
  logic             r_valid;
  logic [SEL_W-1:0] r_idx;
  logic             r_last;

  state_t w_load_state;
  logic   w_load_last;

  // Destination state and last flag for a newly accepted request.
  always_comb begin
    w_load_state = ST_HOLD;
    w_load_last  = 1'b1;
    case (in_mode)
      MODE_DIRECT: begin
        w_load_state = ST_HOLD;
        w_load_last  = 1'b1;
      end
      MODE_SCAN: begin
        w_load_state = ST_SCAN;
        w_load_last  = (in_sel == LAST_IDX);
      end
      default: ;
    endcase
  end

  // HOLD can take a new request in the same cycle its beat drains.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_HOLD: in_ready = out_ready;
      ST_SCAN: in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_state <= w_load_state;
            r_valid <= 1'b1;
            r_idx   <= in_sel;
            r_last  <= w_load_last;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            if (in_valid) begin
              r_state <= w_load_state;
              r_valid <= 1'b1;
              r_idx   <= in_sel;
              r_last  <= w_load_last;
            end else begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_idx   <= '0;
              r_last  <= 1'b0;
            end
          end
        end
        ST_SCAN: begin
          if (out_ready) begin
            if (r_idx == LAST_IDX) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_idx   <= '0;
              r_last  <= 1'b0;
            end else begin
              r_idx  <= r_idx + 1'b1;
              r_last <= ((r_idx + 1'b1) == LAST_IDX);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_idx   <= '0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign out_last  = r_last;

  dec_onehot_core #(
    .SEL_W(SEL_W)
  ) u_core (
    .i_idx  (r_idx),
    .i_en   (r_valid),
    .o_word (out_onehot)
  );

endmodule

// File: tb/tb_decoder_pipe.sv
module tb_decoder_pipe;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;
  logic [SEL_W-1:0] out_idx;
  logic             out_last;

  int n_pass = 0;
  int n_tot  = 0;

  decoder_pipe #(.SEL_W(SEL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_idx    (out_idx),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  // Polarity of the decoded word as seen on the port.
  function automatic logic [OUT_W-1:0] pol(input logic [OUT_W-1:0] w);
`ifdef DECODER_PIPE_ACTIVE_LOW_EN
    return ~w;
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
  endtask

  // Model: the outstanding beats of the current request as a list of indices.
  int q[$];
  bit q_scan;

  function automatic bit m_in_ready();
    if (q.size() == 0) return 1'b1;
    return q_scan ? 1'b0 : out_ready;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit fire;
    if (rst) begin
      q.delete();
      q_scan = 1'b0;
    end else begin
      fire = in_valid && m_in_ready();
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (fire) begin
        q_scan = in_mode;
        if (in_mode) begin
          for (int i = int'(in_sel); i < OUT_W; i++) q.push_back(i);
        end else begin
          q.push_back(int'(in_sel));
        end
      end
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    logic [OUT_W-1:0] hot;
    hot = '0;
    if (q.size() > 0) hot[q[0]] = 1'b1;
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("m_in_ready", {31'd0, in_ready}, {31'd0, m_in_ready()});
    chk("m_onehot", {24'd0, out_onehot}, {24'd0, pol(hot)});
    if (q.size() > 0) begin
      chk("m_out_idx", {29'd0, out_idx}, q[0]);
      chk("m_out_last", {31'd0, out_last}, {31'd0, q.size() == 1});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [SEL_W-1:0] sel, input logic mode);
    in_valid = 1'b1;
    in_sel   = sel;
    in_mode  = mode;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_mode = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_onehot", {24'd0, out_onehot}, {24'd0, pol(8'h00)});
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    tick(); tick();
    rst = 1'b0;
    #1 chk("rel_in_ready", {31'd0, in_ready}, 1);

    // Direct, back-to-back
    tick();
    req(3'd5, 1'b0); out_ready = 1'b1;
    tick();
    in_sel = 3'd2;
    #1;
    chk("dir5_onehot", {24'd0, out_onehot}, {24'd0, pol(8'h20)});
    chk("dir5_idx", {29'd0, out_idx}, 5);
    chk("dir5_last", {31'd0, out_last}, 1);
    chk("dir5_in_ready", {31'd0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("dir2_onehot", {24'd0, out_onehot}, {24'd0, pol(8'h04)});
    chk("dir2_valid", {31'd0, out_valid}, 1);
    tick();
    #1 chk("dir_idle", {31'd0, out_valid}, 0);

    // Scan from 5
    req(3'd5, 1'b1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("scan5_b0", {24'd0, out_onehot}, {24'd0, pol(8'h20)});
    chk("scan5_b0_last", {31'd0, out_last}, 0);
    chk("scan5_b0_rdy", {31'd0, in_ready}, 0);
    tick();
    chk("scan5_b1", {24'd0, out_onehot}, {24'd0, pol(8'h40)});
    chk("scan5_b1_last", {31'd0, out_last}, 0);
    tick();
    chk("scan5_b2", {24'd0, out_onehot}, {24'd0, pol(8'h80)});
    chk("scan5_b2_last", {31'd0, out_last}, 1);
    chk("scan5_b2_rdy", {31'd0, in_ready}, 0);
    tick();
    chk("scan5_end", {31'd0, out_valid}, 0);

    // Backpressure on scan from 6
    out_ready = 1'b0;
    req(3'd6, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_hold", {24'd0, out_onehot}, {24'd0, pol(8'h40)});
      chk("bp_hold_idx", {29'd0, out_idx}, 6);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_rel0", {24'd0, out_onehot}, {24'd0, pol(8'h40)});
    tick();
    chk("bp_rel1", {24'd0, out_onehot}, {24'd0, pol(8'h80)});
    chk("bp_rel1_last", {31'd0, out_last}, 1);
    tick();
    chk("bp_end", {31'd0, out_valid}, 0);

    // Direct under backpressure: a waiting request is accepted only on drain
    out_ready = 1'b0;
    req(3'd3, 1'b0);
    tick();
    in_sel = 3'd4;
    tick(); tick();
    chk("hold_bp_idx", {29'd0, out_idx}, 3);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1 chk("hold_next_idx", {29'd0, out_idx}, 4);
    tick();

    // Scan from the top index: single beat
    req(3'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("scan7_onehot", {24'd0, out_onehot}, {24'd0, pol(8'h80)});
    chk("scan7_last", {31'd0, out_last}, 1);
    tick();
    chk("scan7_end", {31'd0, out_valid}, 0);

    // Abort mid-scan from 0 at index 3
    req(3'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("abort_idx3", {29'd0, out_idx}, 3);
    rst = 1'b1;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 0);
    chk("abort_onehot", {24'd0, out_onehot}, {24'd0, pol(8'h00)});
    chk("abort_idx", {29'd0, out_idx}, 0);
    chk("abort_last", {31'd0, out_last}, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("abort_quiet", {31'd0, out_valid}, 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 Parameter SEL_W, default 3, selector width; SHALL support 1..6.
REQ-002 Derived constant OUT_W = 2**SEL_W, output width; SHALL NOT be overridable.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 in_sel  input  SEL_W  index to decode, or scan start index.
REQ-008 in_mode  input  1  0 = direct (single beat), 1 = scan (walk in_sel..OUT_W-1).
REQ-009 out_valid  output  1  out_onehot/out_idx valid.
REQ-010 out_ready  input  1  consumer accepts beat.
REQ-011 out_onehot  output  OUT_W  decoded one-hot word, bit out_idx set.
REQ-012 out_idx  output  SEL_W  index currently presented.
REQ-013 out_last  output  1  final beat of the current request.

Function
REQ-014 Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
REQ-015 FSM states SHALL be IDLE, HOLD and SCAN.
REQ-016 IDLE: out_valid=0; in_ready=1; fire with mode 0 -> HOLD; fire with mode 1 -> SCAN.
REQ-017 HOLD: out_valid=1; out_last=1; in_ready=out_ready.
REQ-018 HOLD, output fire with input fire: load new request with no bubble; mode 0 -> HOLD, mode 1 -> SCAN.
REQ-019 HOLD, output fire without input fire -> IDLE.
REQ-020 SCAN: out_valid=1; in_ready=0; out_last=1 only when out_idx==OUT_W-1.
REQ-021 SCAN, output fire with out_idx<OUT_W-1: out_idx SHALL increment by 1 next cycle.
REQ-022 SCAN, output fire with out_last=1 -> IDLE; out_idx SHALL never wrap past OUT_W-1.
REQ-023 Latency: out_valid SHALL assert in the cycle after input fire; beats advance at most one per cycle.
REQ-024 Backpressure: while out_valid=1 and out_ready=0, out_onehot, out_idx and out_last SHALL hold stable.
REQ-025 out_onehot SHALL equal 1<<out_idx while out_valid=1, and all zeros while out_valid=0.
REQ-026 Scan starting at in_sel=OUT_W-1 SHALL produce exactly one beat with out_last=1.
REQ-027 Inputs other than in_valid are don't-care when in_valid=0.

Reset
REQ-028 Reset SHALL force state IDLE, out_valid=0, out_onehot=0, out_idx=0 and out_last=0 immediately, without waiting for a clock edge.
REQ-029 Reset asserted mid-scan or mid-hold SHALL abandon the request; no beat of it SHALL appear after release.
REQ-030 After reset release, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-031 Macro DECODER_PIPE_ACTIVE_LOW_EN defined: out_onehot SHALL be one-cold (bit out_idx=0, others 1), all ones when out_valid=0 and at reset.
REQ-032 Macro undefined: active-high behaviour per REQ-025 and REQ-028.

Structure
REQ-033 Shared package dec_pkg SHALL hold the FSM state typedef and the mode constants MODE_DIRECT=0 and MODE_SCAN=1.
REQ-034 Index-to-one-hot conversion SHALL be a sub-module, dec_onehot_core, parametrised by SEL_W, including the polarity option.

Verification (SEL_W=3)
REQ-035 Reset -> out_valid=0, out_onehot=8'h00, in_ready=1; with the macro defined, out_onehot=8'hFF.
REQ-036 Direct: in_sel=5 with out_ready=1 -> next cycle out_onehot=8'h20, out_idx=5, out_last=1; back-to-back in_sel=2 -> 8'h04 with no bubble.
REQ-037 Scan: in_sel=5, mode 1, out_ready=1 -> 8'h20, 8'h40, 8'h80 on consecutive cycles; out_last only on 8'h80; in_ready=0 throughout.
REQ-038 Backpressure: scan from 6 with out_ready=0 for 4 cycles -> 8'h40 held stable; then 8'h40, 8'h80 on release.
REQ-039 Edge and abort: scan from 7 -> single beat 8'h80 with out_last=1; rst asserted mid-scan from 0 at idx 3 -> outputs zero at once and no further beats.
